// File: rtl/cp0_reg.sv
// Coprocessor-0 register file: exception state (EPC/Cause/Status/BadVAddr),
// Count/Compare timer with interrupt, and MFC0/MTC0 access.
module cp0_reg #(
    parameter logic [31:0] PRID_VALUE   = 32'h00004220,
    parameter logic [31:0] CONFIG_VALUE = 32'h00008000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [4:0]  raddr_i,
    input  logic [31:0] data_i,
    input  logic [5:0]  int_i,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] current_inst_addr_i,
    input  logic        is_in_delayslot_i,
    input  logic [31:0] bad_addr_i,
    output logic [31:0] data_o,
    output logic [31:0] badvaddr_o,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic        timer_int_o
);

    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_STATUS   = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;
    localparam logic [4:0] REG_PRID     = 5'd15;
    localparam logic [4:0] REG_CONFIG   = 5'd16;

    localparam logic [31:0] STATUS_RESET = 32'h00400000;

    logic [31:0] r_badvaddr;
    logic [31:0] r_count;
    logic [31:0] r_compare;
    logic [31:0] r_status;
    logic [31:0] r_cause;
    logic [31:0] r_epc;
    logic        r_timer_int;
    logic        r_tick;

    logic        w_exc_take;
    logic        w_exc_adr;
    logic        w_eret;
    logic [4:0]  w_exc_code;
    logic [31:0] w_epc_next;

    // Unknown codes fall through with w_exc_take low, i.e. behave as no exception.
    always_comb begin
        w_exc_take = 1'b1;
        w_exc_adr  = 1'b0;
        w_eret     = 1'b0;
        w_exc_code = '0;
        case (excepttype_i)
            32'h1: w_exc_code = 5'd0;
            32'h4: begin w_exc_code = 5'd4; w_exc_adr = 1'b1; end
            32'h5: begin w_exc_code = 5'd5; w_exc_adr = 1'b1; end
            32'h8: w_exc_code = 5'd8;
            32'h9: w_exc_code = 5'd9;
            32'ha: w_exc_code = 5'd10;
            32'hc: w_exc_code = 5'd12;
            32'he: begin w_exc_take = 1'b0; w_eret = 1'b1; end
            default: w_exc_take = 1'b0;
        endcase
    end

    assign w_epc_next = is_in_delayslot_i ? current_inst_addr_i - 32'd4
                                          : current_inst_addr_i;

    // Later assignments win: MTC0 lands first, exception/ERET fields override it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_badvaddr  <= '0;
            r_count     <= '0;
            r_compare   <= '0;
            r_status    <= STATUS_RESET;
            r_cause     <= '0;
            r_epc       <= '0;
            r_timer_int <= 1'b0;
            r_tick      <= 1'b0;
        end else begin
            r_tick         <= ~r_tick;
            r_cause[15:10] <= int_i;
            if (r_tick) begin
                r_count <= r_count + 32'd1;
            end
            if (r_compare != '0 && r_count == r_compare) begin
                r_timer_int <= 1'b1;
            end

            if (we_i) begin
                case (waddr_i)
                    REG_COUNT:   r_count <= data_i;
                    REG_COMPARE: begin
                        r_compare   <= data_i;
                        r_timer_int <= 1'b0;
                    end
                    REG_STATUS: begin
                        r_status[15:8] <= data_i[15:8];
                        r_status[1:0]  <= data_i[1:0];
                    end
                    REG_CAUSE:   r_cause[9:8] <= data_i[9:8];
                    REG_EPC:     r_epc <= data_i;
                    default:     ;
                endcase
            end

            if (w_exc_take) begin
                if (!r_status[1]) begin
                    r_epc       <= w_epc_next;
                    r_cause[31] <= is_in_delayslot_i;
                end
                r_status[1]  <= 1'b1;
                r_cause[6:2] <= w_exc_code;
                if (w_exc_adr) begin
                    r_badvaddr <= bad_addr_i;
                end
            end else if (w_eret) begin
                r_status[1] <= 1'b0;
            end
        end
    end

    always_comb begin
        data_o = '0;
        case (raddr_i)
            REG_BADVADDR: data_o = r_badvaddr;
            REG_COUNT:    data_o = r_count;
            REG_COMPARE:  data_o = r_compare;
            REG_STATUS:   data_o = r_status;
            REG_CAUSE:    data_o = r_cause;
            REG_EPC:      data_o = r_epc;
            REG_PRID:     data_o = PRID_VALUE;
            REG_CONFIG:   data_o = CONFIG_VALUE;
            default:      data_o = '0;
        endcase
    end

    assign badvaddr_o  = r_badvaddr;
    assign count_o     = r_count;
    assign compare_o   = r_compare;
    assign status_o    = r_status;
    assign cause_o     = r_cause;
    assign epc_o       = r_epc;
    assign timer_int_o = r_timer_int;

endmodule

// File: tb/tb_cp0_reg.sv
// Scoreboard bench for cp0_reg: stimulus pushes reference-model snapshots,
// a monitor compares them after every clock edge.
module tb_cp0_reg;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        we_i = 1'b0;
    logic [4:0]  waddr_i = '0;
    logic [4:0]  raddr_i = '0;
    logic [31:0] data_i = '0;
    logic [5:0]  int_i = '0;
    logic [31:0] excepttype_i = '0;
    logic [31:0] current_inst_addr_i = '0;
    logic        is_in_delayslot_i = 1'b0;
    logic [31:0] bad_addr_i = '0;
    logic [31:0] data_o, badvaddr_o, count_o, compare_o, status_o, cause_o, epc_o;
    logic        timer_int_o;

    cp0_reg #(.PRID_VALUE(32'h00004220), .CONFIG_VALUE(32'h00008000)) dut (
        .clk(clk), .rst(rst), .we_i(we_i), .waddr_i(waddr_i), .raddr_i(raddr_i),
        .data_i(data_i), .int_i(int_i), .excepttype_i(excepttype_i),
        .current_inst_addr_i(current_inst_addr_i), .is_in_delayslot_i(is_in_delayslot_i),
        .bad_addr_i(bad_addr_i), .data_o(data_o), .badvaddr_o(badvaddr_o),
        .count_o(count_o), .compare_o(compare_o), .status_o(status_o),
        .cause_o(cause_o), .epc_o(epc_o), .timer_int_o(timer_int_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        rst, we, ds;
        bit [4:0]  wa, ra;
        bit [5:0]  irq;
        bit [31:0] d, exc, pc, bad;
    } in_t;

    typedef struct packed {
        logic [31:0] badv, count, compare, status, cause, epc, data;
        logic        tint;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model: architectural registers indexed by CP0 number.
    logic [31:0] m [0:31];
    bit          m_tog, m_tint;

    function automatic in_t idle();
        in_t s;
        s = '{default: 0};
        return s;
    endfunction

    function automatic logic [31:0] wmask(input logic [4:0] a);
        case (a)
            5'd9, 5'd11, 5'd14: return 32'hFFFFFFFF;
            5'd12:              return 32'h0000FF03;
            5'd13:              return 32'h00000300;
            default:            return 32'h0;
        endcase
    endfunction

    function automatic int exc_code(input logic [31:0] e);
        case (e)
            32'h1: return 0;  32'h4: return 4;  32'h5: return 5;
            32'h8: return 8;  32'h9: return 9;  32'ha: return 10;
            32'hc: return 12;
            default: return -1;
        endcase
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14: return m[a];
            5'd15: return 32'h00004220;
            5'd16: return 32'h00008000;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model(input in_t s);
        logic [31:0] o [0:31];
        bit          otog;
        int          c;
        o    = m;
        otog = m_tog;
        if (s.rst) begin
            for (int unsigned i = 0; i < 32; i++) m[i] = '0;
            m[12]  = 32'h00400000;
            m_tog  = 1'b0;
            m_tint = 1'b0;
        end else begin
            m_tog  = ~otog;
            m_tint = m_tint | (o[11] != 0 && o[9] == o[11]);
            m[9]   = o[9] + (otog ? 32'd1 : 32'd0);
            m[13][15:10] = s.irq;
            if (s.we) begin
                m[s.wa] = (m[s.wa] & ~wmask(s.wa)) | (s.d & wmask(s.wa));
                if (s.wa == 5'd11) m_tint = 1'b0;
            end
            c = exc_code(s.exc);
            if (c >= 0) begin
                if (!o[12][1]) begin
                    m[14]     = s.ds ? s.pc - 32'd4 : s.pc;
                    m[13][31] = s.ds;
                end
                m[12][1]    = 1'b1;
                m[13][6:2]  = c[4:0];
                if (c == 4 || c == 5) m[8] = s.bad;
            end else if (s.exc == 32'he) begin
                m[12][1] = 1'b0;
            end
        end
    endtask

    // Called at a negedge: drive, predict, queue, then wait for the next negedge.
    task automatic step(input in_t s);
        exp_t e;
        rst = s.rst; we_i = s.we; waddr_i = s.wa; raddr_i = s.ra; data_i = s.d;
        int_i = s.irq; excepttype_i = s.exc; current_inst_addr_i = s.pc;
        is_in_delayslot_i = s.ds; bad_addr_i = s.bad;
        model(s);
        e.badv = m[8]; e.count = m[9]; e.compare = m[11]; e.status = m[12];
        e.cause = m[13]; e.epc = m[14]; e.tint = m_tint; e.data = m_read(s.ra);
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual %h required %h", nm, act, req);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("badvaddr", badvaddr_o, e.badv);
                chk("count", count_o, e.count);
                chk("compare", compare_o, e.compare);
                chk("status", status_o, e.status);
                chk("cause", cause_o, e.cause);
                chk("epc", epc_o, e.epc);
                chk("data_o", data_o, e.data);
                chk("timer_int", {31'b0, timer_int_o}, {31'b0, e.tint});
            end
        end
    end

    initial begin : stim
        in_t s;
        logic [4:0]  wtab [0:8];
        logic [31:0] etab [0:13];
        wtab = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16, 5'd3};
        etab = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h1, 32'h4, 32'h5, 32'h8,
                 32'h9, 32'ha, 32'hc, 32'he, 32'h3, 32'h7};
        for (int unsigned i = 0; i < 32; i++) m[i] = '0;
        m_tog = 1'b0; m_tint = 1'b0;

        @(negedge clk);
        s = idle(); s.rst = 1'b1; step(s);
        for (int i = 0; i < 10; i++) step(idle());
        chk("reset_count", count_o, 32'd5);
        chk("reset_status", status_o, 32'h00400000);
        chk("reset_epc", epc_o, 32'h0);
        chk("reset_cause", cause_o, 32'h0);

        s = idle(); s.we = 1'b1; s.wa = 5'd11; s.d = 32'd8; step(s);
        for (int i = 0; i < 40 && count_o != 32'd8; i++) step(idle());
        chk("timer_count_reached", count_o, 32'd8);
        chk("timer_not_yet", {31'b0, timer_int_o}, 32'd0);
        step(idle());
        chk("timer_rise", {31'b0, timer_int_o}, 32'd1);
        s = idle(); s.we = 1'b1; s.wa = 5'd11; s.d = 32'h20; step(s);
        chk("timer_clear", {31'b0, timer_int_o}, 32'd0);

        s = idle(); s.exc = 32'h4; s.pc = 32'hBFC00100; s.ds = 1'b1; s.bad = 32'h3; step(s);
        chk("adel_epc", epc_o, 32'hBFC000FC);
        chk("adel_bd", {31'b0, cause_o[31]}, 32'd1);
        chk("adel_code", {27'b0, cause_o[6:2]}, 32'd4);
        chk("adel_exl", {31'b0, status_o[1]}, 32'd1);
        chk("adel_badv", badvaddr_o, 32'h3);

        s = idle(); s.exc = 32'h8; s.pc = 32'h80000000; step(s);
        chk("nested_epc", epc_o, 32'hBFC000FC);
        chk("nested_code", {27'b0, cause_o[6:2]}, 32'd8);
        s = idle(); s.exc = 32'he; step(s);
        chk("eret_exl", {31'b0, status_o[1]}, 32'd0);

        s = idle(); s.we = 1'b1; s.wa = 5'd14; s.d = 32'h1234;
        s.exc = 32'hc; s.pc = 32'h80001000; step(s);
        chk("mtc0_exc_epc", epc_o, 32'h80001000);
        chk("mtc0_exc_code", {27'b0, cause_o[6:2]}, 32'd12);

        s = idle(); s.exc = 32'he; step(s);
        s = idle(); s.we = 1'b1; s.wa = 5'd12; s.d = 32'h0000FF01; s.exc = 32'h1; step(s);
        chk("status_im", {24'b0, status_o[15:8]}, 32'hFF);
        chk("status_ie_exl", {30'b0, status_o[1:0]}, 32'd3);

        s = idle(); s.irq = 6'b100001; step(s);
        chk("cause_ip_hw", {26'b0, cause_o[15:10]}, 32'h21);
        s = idle(); s.we = 1'b1; s.wa = 5'd13; s.d = 32'h00000300; s.ra = 5'd15; step(s);
        chk("cause_ip_sw", {30'b0, cause_o[9:8]}, 32'd3);
        chk("prid_read", data_o, 32'h00004220);

        s = idle(); s.rst = 1'b1; step(s);
        chk("midrst_status", status_o, 32'h00400000);
        chk("midrst_epc", epc_o, 32'h0);
        chk("midrst_cause", cause_o, 32'h0);
        chk("midrst_timer", {31'b0, timer_int_o}, 32'd0);

        for (int i = 0; i < 600; i++) begin
            s.rst = ($urandom_range(0, 63) == 0);
            s.we  = ($urandom_range(0, 2) == 0);
            s.wa  = wtab[$urandom_range(0, 8)];
            s.ra  = ($urandom_range(0, 3) == 0) ? 5'($urandom) : wtab[$urandom_range(0, 8)];
            s.d   = $urandom_range(0, 1) ? 32'($urandom_range(0, 15)) : $urandom;
            s.irq = 6'($urandom);
            s.exc = etab[$urandom_range(0, 13)];
            s.pc  = $urandom & 32'hFFFFFFFC;
            s.ds  = 1'($urandom);
            s.bad = $urandom;
            // Status writes coinciding with exception/ERET are left out of the random mix.
            if (s.exc != 32'h0 && s.wa == 5'd12) s.we = 1'b0;
            step(s);
        end

        @(posedge clk);
        #2;
        chk("queue_drained", q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cp0_reg.md
Name: cp0_reg

Overview:
- Coprocessor-0 register file. Consumes the prioritised `excepttype` code and updates EPC, Cause, Status and BadVAddr.
- Runs the Count/Compare timer and raises the timer interrupt.
- Serves MFC0 reads and MTC0 writes.
- Sits in the memory/writeback stage. Its status/cause outputs feed back into exception prioritisation, and its epc output feeds the PC-redirect logic.

Parameters:
- PRID_VALUE, 32'h00004220, constant returned for PRId (reg 15).
- CONFIG_VALUE, 32'h00008000, constant returned for Config (reg 16).

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- we_i  in  1  MTC0 write enable
- waddr_i  in  5  MTC0 destination register number
- raddr_i  in  5  MFC0 source register number
- data_i  in  32  MTC0 write data
- int_i  in  6  external hardware interrupt lines
- excepttype_i  in  32  code: 0x1 Int, 0x4 AdEL, 0x5 AdES, 0x8 Sys, 0x9 Bp, 0xa RI, 0xc Ov, 0xe ERET, 0x0 none
- current_inst_addr_i  in  32  PC of the excepting instruction
- is_in_delayslot_i  in  1  excepting instruction is in a branch delay slot
- bad_addr_i  in  32  faulting virtual address for AdEL/AdES
- data_o  out  32  MFC0 read data, combinational
- badvaddr_o, count_o, compare_o, status_o, cause_o, epc_o  out  32 each  live register values
- timer_int_o  out  1  timer interrupt request

Behaviour:
- Reset (rst=1 at an edge):
  - Count, Compare, Cause, EPC and BadVAddr = 0.
  - Status = 32'h00400000 (BEV=1).
  - timer_int_o = 0.
  - Count divider toggle = 0.
- Count:
  - The divider toggles every cycle.
  - Count increments when the toggle is 1, i.e. once per 2 cycles; it wraps 0xFFFFFFFF -> 0.
  - An MTC0 to Count loads data_i, overriding that cycle's increment. The toggle is not reset.
- Timer:
  - timer_int_o is set to 1 when Compare != 0 and Count == Compare, evaluated on the registered values.
  - It holds until an MTC0 to Compare, which clears it in the same edge.
  - A Compare write together with a match in the same cycle leaves timer_int_o = 0.
- Cause IP:
  - Cause[15:10] <= int_i every cycle.
  - Cause[9:8] (software interrupts) are writable by MTC0 only.
- MTC0 writable fields (others ignored or read-only):
  - Count (9), full width.
  - Compare (11), full width.
  - Status (12): [15:8] IM, [1] EXL, [0] IE.
  - Cause (13): [9:8] only.
  - EPC (14), full width.
  - Writes to BadVAddr, PRId or Config have no effect.
- Exception entry (excepttype_i ∉ {0x0, 0xe}):
  - If Status.EXL == 0:
    - EPC <= is_in_delayslot_i ? current_inst_addr_i - 4 : current_inst_addr_i.
    - Cause[31] (BD) <= is_in_delayslot_i.
  - If Status.EXL == 1: EPC and BD are unchanged.
  - Always: Status.EXL <= 1.
  - Cause[6:2] ExcCode <= 0 (Int), 4, 5, 8, 9, 10 or 12 respectively.
  - For 0x4/0x5 only: BadVAddr <= bad_addr_i.
- ERET (0xe): Status.EXL <= 0. Nothing else changes.
- Unknown nonzero code: treated as no exception.
- Same cycle MTC0 + exception:
  - The MTC0 write is applied first.
  - Exception updates override any overlapping fields (EPC, EXL, BD, ExcCode, BadVAddr).
  - Non-overlapping MTC0 fields still commit.
- Read path:
  - data_o is the current register value by raddr_i.
  - PRId returns PRID_VALUE and Config returns CONFIG_VALUE.
  - Unmapped numbers return 0.
  - No write forwarding: the new value is visible the cycle after the write.
- Mid-operation reset: all state returns to reset values at that edge; pending timer interrupt and EXL are cleared.

Test Plan:
- Reset, then 10 idle cycles -> count_o = 5, status_o = 0x00400000, all other outputs 0.
- MTC0 Compare = 8, idle -> timer_int_o rises the cycle after Count reaches 8.
- Then MTC0 Compare = 0x20 -> timer_int_o = 0 after that edge.
- excepttype_i = 0x4, pc = 0xBFC00100, delayslot = 1, bad_addr = 0x00000003 -> epc_o = 0xBFC000FC, cause_o[31] = 1, cause_o[6:2] = 4, status_o[1] = 1, badvaddr_o = 3.
- With EXL = 1, excepttype_i = 0x8, pc = 0x80000000 -> epc_o unchanged, ExcCode = 8.
- Then excepttype_i = 0xe -> status_o[1] = 0.
- Same cycle: MTC0 EPC = 0x1234 and excepttype_i = 0xc, pc = 0x80001000, EXL = 0 -> epc_o = 0x80001000, ExcCode = 12.
- Separate same-cycle case: MTC0 Status = 0x0000FF01 and exception 0x1 -> IM = 0xFF, IE = 1, EXL = 1.
- int_i = 6'b100001 -> cause_o[15:10] = 6'b100001 one cycle later.
- MTC0 Cause = 0x00000300 -> cause_o[9:8] = 2'b11.
- rst asserted mid-stream -> all registers return to reset values.
